// File: rtl/gray_counter.sv
// Up/down binary counter that presents each new count together with its Gray
// code on a valid/ready port. Supports wrap/saturate modes, parallel load and a
// terminal-count flag.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             saturate,
    input  logic             ready,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] G,
    output logic             valid,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // G[MSB] = B[MSB], G[i] = B[i+1] ^ B[i]
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_word;
    logic             free;
    logic             at_limit;
    logic             step_ok;
    logic             take_word;
    logic             tc_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        next_word = cnt;
        free      = !valid || ready;
        at_limit  = up ? (cnt == ALL_ONES) : (cnt == '0);
        step_ok   = en && !(saturate && at_limit);
        take_word = free && (load || step_ok);
        if (load) begin
            next_word = load_val;
        end else if (up) begin
            next_word = cnt + ONE;
        end else begin
            next_word = cnt - ONE;
        end
        // Terminal flag follows the direction sampled on the producing cycle.
        tc_next = up ? (next_word == ALL_ONES) : (next_word == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples the pre-edge values regardless of statement order.
            cnt   <= '0;
            B     <= '0;
            G     <= '0;
            valid <= 1'b0;
            tc    <= 1'b0;
        end else if (take_word) begin
            cnt   <= next_word;
            B     <= next_word;
            G     <= to_gray(next_word);
            valid <= 1'b1;
            tc    <= tc_next;
        end else if (free) begin
            // Slot free but nothing new: any held word was consumed or none existed.
            valid <= 1'b0;
            tc    <= 1'b0;
        end
    end

endmodule
